mem_access: RTL
===============

Name: mem_access

Overview:
- MEM pipeline stage. It consumes the EX-stage results: ALU op, register write info, RAM address and store data.
- For LB/LW/SB/SW it runs a req/ack transaction on the data-RAM port and stalls the pipeline until that transaction completes.
- It produces the write-back register for the MEM/WB latch.
- Non-memory ops pass through with zero latency.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles to wait for ram_ack_i before aborting with a bus error; must be ≥ 2.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset (reset_status_t; RST_ENABLE = 1'b0).
- mem_alu_i  input  alu_t  op/sel from EX (LB_OP, LW_OP, SB_OP, SW_OP, others).
- mem_wreg_i  input  reg_t  en/addr/data from EX.
- mem_ramaddr_i  input  32  effective address from EX.
- mem_sdata_i  input  32  store data (rt value).
- mem_wreg_o  output  reg_t  write-back register to MEM/WB.
- mem_stallreq  output  1  pipeline stall request to the controller.
- mem_buserr_o  output  1  one-cycle pulse on timeout abort.
- ram_req_o  output  1  data-RAM request.
- ram_we_o  output  1  1 = write.
- ram_addr_o  output  32  word-aligned address ({addr[31:2],2'b00}).
- ram_be_o  output  4  byte enables.
- ram_wdata_o  output  32  write data.
- ram_ack_i  input  1  single-cycle completion strobe.
- ram_rdata_i  input  32  read data, valid with ram_ack_i.

Behaviour:
- Reset (rst == RST_ENABLE at clock edge):
  - State goes to IDLE and the timeout counter clears.
  - All registered outputs go to 0: ram_req_o, ram_we_o, ram_addr_o, ram_be_o, ram_wdata_o, mem_buserr_o.
  - While rst is active, mem_wreg_o = '0 and mem_stallreq = 0.
  - Reset mid-transaction aborts it: req drops the next cycle, and a late ack is ignored.
- FSM states: IDLE, WAIT, DONE.
- IDLE, non-memory op:
  - mem_wreg_o = mem_wreg_i combinationally; no stall.
- IDLE, memory op:
  - mem_stallreq = 1 and mem_wreg_o.en = 0 in the same cycle.
  - Next edge: register ram_req_o = 1 together with we/addr/be/wdata, clear the counter, go to WAIT.
- WAIT:
  - mem_stallreq = 1; req/we/addr/be/wdata are held stable.
  - The counter increments each cycle.
  - On ram_ack_i: drop req next edge, capture load data, go to DONE.
  - On counter == TIMEOUT_CYCLES-1 without ack: drop req, set error flag, go to DONE.
  - If ack and timeout occur in the same cycle, the ack wins.
- DONE, one cycle:
  - mem_stallreq = 0.
  - Load: mem_wreg_o = {en, addr from mem_wreg_i, captured data}.
  - Store: mem_wreg_o.en = 0.
  - Error: mem_wreg_o.en = 0 and mem_buserr_o = 1.
  - Next state is IDLE. The controller advances the pipeline at the end of DONE, so the next op is seen fresh in IDLE and back-to-back memory ops work.
- The controller holds all *_i inputs stable while mem_stallreq = 1.
- Byte lanes (big-endian): addr[1:0] 00→be 1000 (bits 31:24), 01→0100, 10→0010, 11→0001.
- SB: be per lane, wdata = {4{sdata[7:0]}}.
- SW/LW: be = 1111, wdata = sdata.
- LB: be per lane; result = selected byte sign-extended to 32 bits.
- ram_ack_i in IDLE or DONE is ignored.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- When defined, LW/SW with addr[1:0] ≠ 00 issue no RAM request. The block goes IDLE→DONE with the error path taken (mem_buserr_o pulse, en = 0), costing one stall cycle.
- When undefined, address bits [1:0] are ignored for word ops and the access uses the aligned word.

Decomposition:
- Shared package (project_types / decode_table):
  - mem_state_t enum.
  - RAM byte-enable constants BE_NONE, BE_WORD.
- Natural sub-module: mem_lane_sel, a combinational block taking op, addr[1:0], sdata and rdata, producing be, wdata and the extended load result.

Test Plan:
- ADD_OP, wreg {en=1, addr=5, data=0x1234} → same cycle mem_wreg_o identical, stallreq = 0, ram_req_o stays 0.
- LW addr 0x100, ack after 3 cycles with rdata 0xDEADBEEF → addr_o = 0x100, be = 1111, stall for 4 cycles, DONE wreg.data = 0xDEADBEEF.
- LB addr 0x103, rdata 0x000000F0 → be = 0001, result 0xFFFFFFF0; with addr 0x100 and rdata 0x7F000000 → be = 1000, result 0x0000007F.
- SB addr 0x102, sdata 0x000000AB → we = 1, be = 0010, wdata = 0xABABABAB, wreg_o.en = 0 in DONE.
- No ack (TIMEOUT_CYCLES = 16) → req high for exactly 16 cycles, then buserr pulse for 1 cycle, en = 0, stall released.
- Reset asserted in WAIT cycle 2, ack arriving the cycle after → state IDLE, req = 0, ack ignored, no write-back. With MEM_ALIGN_CHECK_EN, SW at 0x101 → no req, buserr pulse.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types for the MEM stage: ALU op codes, write-back register, FSM states
// and data-RAM byte-enable constants.
package mem_access_pkg;

  typedef enum logic {RST_ENABLE = 1'b0, RST_DISABLE = 1'b1} reset_status_t;

  typedef enum logic [3:0] {
    NOP_OP, ADD_OP, SUB_OP, AND_OP, OR_OP, LB_OP, LW_OP, SB_OP, SW_OP
  } alu_t;

  typedef struct packed {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } reg_t;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} mem_state_t;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic logic is_mem_op(alu_t op);
    return op inside {LB_OP, LW_OP, SB_OP, SW_OP};
  endfunction

  function automatic logic is_store(alu_t op);
    return op inside {SB_OP, SW_OP};
  endfunction

  function automatic logic is_load(alu_t op);
    return op inside {LB_OP, LW_OP};
  endfunction

endpackage

// File: rtl/mem_lane_sel.sv
// Big-endian byte-lane steering: byte enables and replicated store data,
// plus sign-extended load data for byte loads.
module mem_lane_sel
  import mem_access_pkg::*;
(
  input  alu_t        op_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] sdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o
);

  logic [3:0] lane_be;
  logic [7:0] lane_byte;

  always_comb begin
    // addr 00 addresses the most significant byte
    lane_be = 4'b1000 >> addr_i;
    case (addr_i)
      2'b00:   lane_byte = rdata_i[31:24];
      2'b01:   lane_byte = rdata_i[23:16];
      2'b10:   lane_byte = rdata_i[15:8];
      default: lane_byte = rdata_i[7:0];
    endcase

    be_o    = BE_NONE;
    wdata_o = '0;
    ldata_o = rdata_i;
    case (op_i)
      LB_OP: begin
        be_o    = lane_be;
        ldata_o = {{24{lane_byte[7]}}, lane_byte};
      end
      SB_OP: begin
        be_o    = lane_be;
        wdata_o = {4{sdata_i[7:0]}};
      end
      LW_OP: be_o = BE_WORD;
      SW_OP: begin
        be_o    = BE_WORD;
        wdata_o = sdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: req/ack data-RAM transaction with stall and timeout abort.
// MEM_ALIGN_CHECK_EN: misaligned LW/SW fault without touching the RAM.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  alu_t        mem_alu_i,
  input  reg_t        mem_wreg_i,
  input  logic [31:0] mem_ramaddr_i,
  input  logic [31:0] mem_sdata_i,
  output reg_t        mem_wreg_o,
  output logic        mem_stallreq,
  output logic        mem_buserr_o,
  output logic        ram_req_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [3:0]  ram_be_o,
  output logic [31:0] ram_wdata_o,
  input  logic        ram_ack_i,
  input  logic [31:0] ram_rdata_i
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  mem_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        req_q, req_d, we_q, we_d, buserr_q, buserr_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, ldata_q, ldata_d;
  logic [3:0]  be_q, be_d;

  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_ldata;
  logic        mem_op, misalign;

  mem_lane_sel u_lane (
    .op_i   (mem_alu_i),
    .addr_i (mem_ramaddr_i[1:0]),
    .sdata_i(mem_sdata_i),
    .rdata_i(ram_rdata_i),
    .be_o   (lane_be),
    .wdata_o(lane_wdata),
    .ldata_o(lane_ldata)
  );

  assign mem_op = is_mem_op(mem_alu_i);

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = (mem_alu_i inside {LW_OP, SW_OP}) && (mem_ramaddr_i[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    ldata_d  = ldata_q;
    buserr_d = 1'b0;
    case (state_q)
      IDLE: if (mem_op) begin
        if (misalign) begin
          buserr_d = 1'b1;
          state_d  = DONE;
        end else begin
          req_d   = 1'b1;
          we_d    = is_store(mem_alu_i);
          addr_d  = {mem_ramaddr_i[31:2], 2'b00};
          be_d    = lane_be;
          wdata_d = lane_wdata;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // ack has priority over a coincident timeout
        if (ram_ack_i) begin
          req_d   = 1'b0;
          ldata_d = lane_ldata;
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          req_d    = 1'b0;
          buserr_d = 1'b1;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      ldata_q  <= '0;
      buserr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      ldata_q  <= ldata_d;
      buserr_q <= buserr_d;
    end
  end

  always_comb begin
    mem_wreg_o   = mem_wreg_i;
    mem_stallreq = 1'b0;
    if (rst == RST_ENABLE) begin
      mem_wreg_o = '0;
    end else begin
      case (state_q)
        IDLE: if (mem_op) begin
          mem_stallreq  = 1'b1;
          mem_wreg_o.en = 1'b0;
        end
        WAIT: begin
          mem_stallreq  = 1'b1;
          mem_wreg_o.en = 1'b0;
        end
        default: begin
          if (buserr_q || !is_load(mem_alu_i)) mem_wreg_o.en = 1'b0;
          else mem_wreg_o.data = ldata_q;
        end
      endcase
    end
  end

  assign ram_req_o    = req_q;
  assign ram_we_o     = we_q;
  assign ram_addr_o   = addr_q;
  assign ram_be_o     = be_q;
  assign ram_wdata_o  = wdata_q;
  assign mem_buserr_o = buserr_q;

endmodule
